// File: rtl/ddr_burst_writer_if.sv
// Frame-FIFO show-ahead read port plus Avalon-MM write master port of ddr_burst_writer.
// master = the burst writer; slave = FIFO and DDR controller side.
interface ddr_burst_writer_if #(
    parameter int USEDW_W = 9
);
    logic [95:0]        fifo_q;
    logic               fifo_empty;
    logic [USEDW_W-1:0] fifo_usedw;
    logic               fifo_rdreq;

    logic               avl_ready;
    logic [28:0]        avl_address;
    logic               avl_write;
    logic               avl_burstbegin;
    logic [6:0]         avl_size;
    logic [63:0]        avl_wdata;
    logic [7:0]         avl_be;

    modport master (
        input  fifo_q, fifo_empty, fifo_usedw, avl_ready,
        output fifo_rdreq, avl_address, avl_write, avl_burstbegin,
               avl_size, avl_wdata, avl_be
    );

    modport slave (
        output fifo_q, fifo_empty, fifo_usedw, avl_ready,
        input  fifo_rdreq, avl_address, avl_write, avl_burstbegin,
               avl_size, avl_wdata, avl_be
    );
endinterface

// File: rtl/ddr_burst_writer.sv
// Drains the packed-frame FIFO into fixed-length Avalon-MM burst writes to DDR.
// Optional macro BURST_CHECK_EN adds the sticky err_align burst/frame marker checker.
module ddr_burst_writer #(
    parameter int BURST_LEN = 32,
    parameter int USEDW_W   = 9
) (
    input  logic                clk_100,
    input  logic                reset_n,
    input  logic                wr_enable,
    ddr_burst_writer_if.master  bus,
    output logic                busy,
    output logic                frame_done,
    output logic [13:0]         burst_cnt
`ifdef BURST_CHECK_EN
    ,
    output logic                err_align
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [5:0]         LAST_BEAT = 6'(BURST_LEN - 1);
    localparam logic [USEDW_W-1:0] FILL_MIN  = USEDW_W'(BURST_LEN);

    state_t      state_q, state_d;
    logic [5:0]  beat_cnt_q, beat_cnt_d;
    logic [28:0] addr_q, addr_d;
    logic [13:0] burst_cnt_q, burst_cnt_d;
    logic        frame_end_q, frame_end_d;

    logic        accept;
    logic        is_last_beat;
    logic        head_valid;
    logic        head_last_burst;
    logic        head_last_frame;
    logic        rdreq;
    logic        write;
    logic        burstbegin;
    logic [63:0] wdata;

    assign head_valid      = bus.fifo_q[93];
    assign head_last_frame = bus.fifo_q[94];
    assign head_last_burst = bus.fifo_q[95];
    assign is_last_beat    = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        addr_d      = addr_q;
        burst_cnt_d = burst_cnt_q;
        frame_end_d = frame_end_q;
        rdreq       = 1'b0;
        write       = 1'b0;
        burstbegin  = 1'b0;
        wdata       = '0;
        accept      = 1'b0;
        frame_done  = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Invalid heads are discarded before any fill-level check.
                if (!bus.fifo_empty && !head_valid) begin
                    rdreq = 1'b1;
                end else if (wr_enable && (bus.fifo_usedw >= FILL_MIN) && head_valid) begin
                    addr_d     = bus.fifo_q[92:64];
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end

            BURST: begin
                write      = !bus.fifo_empty;
                wdata      = bus.fifo_q[63:0];
                burstbegin = write && (beat_cnt_q == 6'd0);
                accept     = write && bus.avl_ready;
                rdreq      = accept;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 6'd1;
                    if (is_last_beat) begin
                        beat_cnt_d  = '0;
                        burst_cnt_d = burst_cnt_q + 14'd1;
                        state_d     = DONE;
                        if (head_last_frame) begin
                            frame_end_d = 1'b1;
                        end
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
                if (frame_end_q) begin
                    frame_done  = 1'b1;
                    burst_cnt_d = '0;
                    frame_end_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            addr_q      <= '0;
            burst_cnt_q <= '0;
            frame_end_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            addr_q      <= addr_d;
            burst_cnt_q <= burst_cnt_d;
            frame_end_q <= frame_end_d;
        end
    end

`ifdef BURST_CHECK_EN
    logic err_align_q, err_align_d;
    logic misaligned;

    // Burst marker must appear exactly on the final beat; frame marker needs a burst marker.
    always_comb begin
        misaligned  = (head_last_burst && !is_last_beat) ||
                      (!head_last_burst && is_last_beat) ||
                      (head_last_frame && !head_last_burst);
        err_align_d = err_align_q || (accept && misaligned);
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            err_align_q <= 1'b0;
        end else begin
            err_align_q <= err_align_d;
        end
    end

    assign err_align = err_align_q;
`else
    logic unused_marker;
    assign unused_marker = head_last_burst;
`endif

    assign bus.fifo_rdreq     = rdreq;
    assign bus.avl_write      = write;
    assign bus.avl_burstbegin = burstbegin;
    assign bus.avl_wdata      = wdata;
    assign bus.avl_address    = addr_q;
    assign bus.avl_size       = 7'(BURST_LEN);
    assign bus.avl_be         = 8'hFF;
    assign busy               = (state_q != IDLE);
    assign burst_cnt          = burst_cnt_q;

endmodule

// File: tb/tb_ddr_burst_writer.sv
// Directed self-checking bench for ddr_burst_writer with a show-ahead FIFO model.
// Define BURST_CHECK_EN to also exercise the err_align checker.
module tb_ddr_burst_writer;

    localparam int BL = 32;

    logic        clk_100 = 1'b0;
    logic        reset_n;
    logic        wr_enable;
    logic        busy;
    logic        frame_done;
    logic [13:0] burst_cnt;
`ifdef BURST_CHECK_EN
    logic        err_align;
`endif

    ddr_burst_writer_if #(.USEDW_W(9)) bus ();

    ddr_burst_writer #(.BURST_LEN(BL), .USEDW_W(9)) dut (
        .clk_100    (clk_100),
        .reset_n    (reset_n),
        .wr_enable  (wr_enable),
        .bus        (bus),
        .busy       (busy),
        .frame_done (frame_done),
        .burst_cnt  (burst_cnt)
`ifdef BURST_CHECK_EN
        ,
        .err_align  (err_align)
`endif
    );

    always #5 clk_100 = ~clk_100;

    logic [95:0] fq[$];
    logic [63:0] acc_data[$];
    logic [28:0] acc_addr[$];
    logic        acc_bb[$];
    int          acc_cyc[$];

    int cyc = 0;
    int pops, wr_cycles, fd_count, fd_cyc, last_frame_cyc, stalls, stall_err;
    bit pop_pending, prev_stall, prev_bb;
    logic [63:0] prev_data;

    int checks   = 0;
    int failures = 0;

    function automatic logic [95:0] mk(input logic lb, input logic lf, input logic v,
                                       input logic [28:0] a, input logic [63:0] d);
        return {lb, lf, v, a, d};
    endfunction

    function automatic void update_fifo();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_usedw = 9'(fq.size());
        bus.fifo_q     = (fq.size() != 0) ? fq[0] : 96'd0;
    endfunction

    function automatic void clear_logs();
        acc_data.delete(); acc_addr.delete(); acc_bb.delete(); acc_cyc.delete();
        pops = 0; wr_cycles = 0; fd_count = 0; fd_cyc = -1; last_frame_cyc = -100;
        stalls = 0; stall_err = 0; pop_pending = 0; prev_stall = 0; prev_bb = 0; prev_data = '0;
    endfunction

    // Monitor samples mid-cycle: a beat seen with write&ready is accepted at the next rising edge.
    always @(negedge clk_100) begin
        #2;
        if (bus.avl_write) wr_cycles++;
        if (prev_stall && (bus.avl_write !== 1'b1 || bus.avl_wdata !== prev_data ||
                           bus.avl_burstbegin !== prev_bb)) stall_err++;
        prev_stall = bus.avl_write && !bus.avl_ready;
        if (prev_stall) begin
            stalls++;
            prev_data = bus.avl_wdata;
            prev_bb   = bus.avl_burstbegin;
        end
        if (bus.avl_write && bus.avl_ready) begin
            acc_data.push_back(bus.avl_wdata);
            acc_addr.push_back(bus.avl_address);
            acc_bb.push_back(bus.avl_burstbegin);
            acc_cyc.push_back(cyc);
            if (bus.fifo_q[94]) last_frame_cyc = cyc;
        end
        if (frame_done) begin
            fd_count++;
            fd_cyc = cyc;
        end
        pop_pending = bus.fifo_rdreq;
    end

    // FIFO model pops just after the edge on which rdreq was seen high.
    always @(posedge clk_100) begin
        cyc++;
        #1;
        if (pop_pending && fq.size() > 0) begin
            void'(fq.pop_front());
            pops++;
        end
        pop_pending = 0;
        update_fifo();
    end

    task automatic do_reset();
        @(negedge clk_100);
        reset_n       = 1'b0;
        wr_enable     = 1'b0;
        bus.avl_ready = 1'b0;
        fq.delete();
        update_fifo();
        repeat (2) @(negedge clk_100);
        reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic push_burst(input logic [28:0] base, input logic [63:0] dbase,
                              input logic frame_end, input int err_beat);
        for (int i = 0; i < BL; i++) begin
            fq.push_back(mk((i == BL-1) || (i == err_beat), frame_end && (i == BL-1), 1'b1,
                            (i == BL-1) ? base + 29'(BL) : base, dbase + 64'(i)));
        end
        update_fifo();
    endtask

    task automatic wait_done(input int target, input bit toggle, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_100);
            if (toggle) bus.avl_ready = ~bus.avl_ready;
            #3;
            if (acc_data.size() >= target && !busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; wr_enable = 1'b0; bus.avl_ready = 1'b0;
        fq.delete(); update_fifo(); clear_logs();
        repeat (2) @(negedge clk_100);
        #3;
        checks++;
        if ({busy, bus.avl_write, bus.avl_burstbegin, bus.fifo_rdreq, frame_done} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                     {busy, bus.avl_write, bus.avl_burstbegin, bus.fifo_rdreq, frame_done});
        end
        checks++;
        if (bus.avl_address !== 29'd0 || burst_cnt !== 14'd0) begin
            failures++;
            $display("[TB] FAIL reset_regs: addr %0h cnt %0d expected 0 0", bus.avl_address, burst_cnt);
        end
        checks++;
        if (bus.avl_size !== 7'd32 || bus.avl_be !== 8'hFF) begin
            failures++;
            $display("[TB] FAIL reset_consts: size %0d be %0h expected 32 ff", bus.avl_size, bus.avl_be);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single_burst();
        bit ok;
        do_reset();
        @(negedge clk_100);
        push_burst(29'h100, 64'd0, 1'b0, -1);
        bus.avl_ready = 1'b1;
        repeat (3) @(negedge clk_100);
        #3;
        checks++;
        if (busy !== 1'b0 || bus.avl_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_enable_low: busy %b write %b expected 0 0", busy, bus.avl_write);
        end
        @(negedge clk_100);
        wr_enable = 1'b1;
        @(negedge clk_100);
        #3;
        checks++;
        if ({bus.avl_write, bus.avl_burstbegin} !== 2'b11) begin
            failures++;
            $display("[TB] FAIL start_latency: write/bb %b expected 11", {bus.avl_write, bus.avl_burstbegin});
        end
        wait_done(BL, 1'b0, 200, ok);
        checks++;
        if (!ok || acc_data.size() != BL) begin
            failures++;
            $display("[TB] FAIL single_beats: got %0d beats (done=%0b) expected 32", acc_data.size(), ok);
        end
        if (acc_data.size() >= BL) begin
            for (int i = 0; i < BL; i++) begin
                checks++;
                if (acc_data[i] !== 64'(i) || acc_addr[i] !== 29'h100 || acc_bb[i] !== (i == 0)) begin
                    failures++;
                    $display("[TB] FAIL single_beat%0d: data %0h addr %0h bb %b expected %0h 100 %b",
                             i, acc_data[i], acc_addr[i], acc_bb[i], i, i == 0);
                end
            end
        end
        checks++;
        if (burst_cnt !== 14'd1 || fd_count != 0 || pops != BL) begin
            failures++;
            $display("[TB] FAIL single_end: cnt %0d fd %0d pops %0d expected 1 0 32", burst_cnt, fd_count, pops);
        end
    endtask

    task automatic test_ready_toggle();
        bit ok;
        do_reset();
        @(negedge clk_100);
        push_burst(29'h400, 64'h1000, 1'b0, -1);
        bus.avl_ready = 1'b1;
        wr_enable = 1'b1;
        wait_done(BL, 1'b1, 300, ok);
        bus.avl_ready = 1'b1;
        checks++;
        if (!ok || acc_data.size() != BL || pops != BL || fq.size() != 0) begin
            failures++;
            $display("[TB] FAIL toggle_count: beats %0d pops %0d left %0d expected 32 32 0",
                     acc_data.size(), pops, fq.size());
        end
        if (acc_data.size() >= BL) begin
            for (int i = 0; i < BL; i++) begin
                checks++;
                if (acc_data[i] !== 64'h1000 + 64'(i) || acc_bb[i] !== (i == 0)) begin
                    failures++;
                    $display("[TB] FAIL toggle_beat%0d: data %0h bb %b expected %0h %b",
                             i, acc_data[i], acc_bb[i], 64'h1000 + 64'(i), i == 0);
                end
            end
        end
        checks++;
        if (stalls == 0 || stall_err != 0) begin
            failures++;
            $display("[TB] FAIL toggle_stall: stalls %0d unstable %0d expected >0 0", stalls, stall_err);
        end
    endtask

    task automatic test_back_to_back_frame();
        bit ok;
        logic [63:0] exp_d;
        logic [28:0] exp_a;
        do_reset();
        @(negedge clk_100);
        push_burst(29'h200, 64'd0, 1'b0, -1);
        push_burst(29'h220, 64'd32, 1'b0, -1);
        push_burst(29'h240, 64'd64, 1'b1, -1);
        bus.avl_ready = 1'b1;
        wr_enable = 1'b1;
        wait_done(3*BL, 1'b0, 400, ok);
        checks++;
        if (!ok || acc_data.size() != 3*BL) begin
            failures++;
            $display("[TB] FAIL frame_beats: got %0d expected 96", acc_data.size());
        end
        if (acc_data.size() >= 3*BL) begin
            for (int i = 0; i < 3*BL; i++) begin
                exp_d = 64'(i);
                exp_a = 29'h200 + 29'(32 * (i / BL));
                checks++;
                if (acc_data[i] !== exp_d || acc_addr[i] !== exp_a || acc_bb[i] !== (i % BL == 0)) begin
                    failures++;
                    $display("[TB] FAIL frame_beat%0d: data %0h addr %0h bb %b expected %0h %0h %b",
                             i, acc_data[i], acc_addr[i], acc_bb[i], exp_d, exp_a, i % BL == 0);
                end
            end
            checks++;
            if (acc_cyc[BL] - acc_cyc[BL-1] != 3 || acc_cyc[2*BL] - acc_cyc[2*BL-1] != 3) begin
                failures++;
                $display("[TB] FAIL b2b_gap: gaps %0d %0d expected 3 3",
                         acc_cyc[BL] - acc_cyc[BL-1], acc_cyc[2*BL] - acc_cyc[2*BL-1]);
            end
        end
        checks++;
        if (fd_count != 1 || fd_cyc != last_frame_cyc + 1) begin
            failures++;
            $display("[TB] FAIL frame_done: pulses %0d at %0d expected 1 at %0d", fd_count, fd_cyc, last_frame_cyc + 1);
        end
        checks++;
        if (burst_cnt !== 14'd0) begin
            failures++;
            $display("[TB] FAIL frame_cnt_clear: got %0d expected 0", burst_cnt);
        end
    endtask

    task automatic test_invalid_drop();
        bit ok;
        int c0;
        do_reset();
        @(negedge clk_100);
        c0 = cyc;
        for (int i = 0; i < 5; i++) fq.push_back(mk(1'b0, 1'b0, 1'b0, 29'h777, 64'hDEAD + 64'(i)));
        push_burst(29'h300, 64'h500, 1'b0, -1);
        bus.avl_ready = 1'b1;
        wr_enable = 1'b1;
        wait_done(BL, 1'b0, 200, ok);
        checks++;
        if (!ok || acc_data.size() != BL || wr_cycles != BL || pops != BL + 5) begin
            failures++;
            $display("[TB] FAIL drop_counts: beats %0d writes %0d pops %0d expected 32 32 37",
                     acc_data.size(), wr_cycles, pops);
        end
        if (acc_data.size() >= BL) begin
            checks++;
            if (acc_cyc[0] != c0 + 6) begin
                failures++;
                $display("[TB] FAIL drop_start: first beat cycle %0d expected %0d", acc_cyc[0], c0 + 6);
            end
            for (int i = 0; i < BL; i++) begin
                checks++;
                if (acc_data[i] !== 64'h500 + 64'(i) || acc_addr[i] !== 29'h300) begin
                    failures++;
                    $display("[TB] FAIL drop_beat%0d: data %0h addr %0h expected %0h 300",
                             i, acc_data[i], acc_addr[i], 64'h500 + 64'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        bit hit;
        do_reset();
        @(negedge clk_100);
        push_burst(29'h600, 64'h2000, 1'b0, -1);
        bus.avl_ready = 1'b1;
        wr_enable = 1'b1;
        hit = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            #3;
            if (acc_data.size() >= 11) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit || bus.avl_wdata !== 64'h200A) begin
            failures++;
            $display("[TB] FAIL midreset_reach: reached %0b data %0h expected 1 200a", hit, bus.avl_wdata);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, bus.avl_write, bus.avl_burstbegin, bus.fifo_rdreq, frame_done} !== 5'b0 ||
            bus.avl_address !== 29'd0 || bus.avl_wdata !== 64'd0 || burst_cnt !== 14'd0) begin
            failures++;
            $display("[TB] FAIL midreset_outputs: ctrl %b addr %0h data %0h cnt %0d expected 0 0 0 0",
                     {busy, bus.avl_write, bus.avl_burstbegin, bus.fifo_rdreq, frame_done},
                     bus.avl_address, bus.avl_wdata, burst_cnt);
        end
        @(negedge clk_100);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_100);
        #3;
        checks++;
        if (busy !== 1'b0 || burst_cnt !== 14'd0 || bus.avl_write !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midreset_after: busy %b cnt %0d write %b expected 0 0 0",
                     busy, burst_cnt, bus.avl_write);
        end
    endtask

`ifdef BURST_CHECK_EN
    task automatic test_err_align();
        bit ok;
        do_reset();
        @(negedge clk_100);
        push_burst(29'h700, 64'h3000, 1'b0, 15);
        bus.avl_ready = 1'b1;
        wr_enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_100);
            #3;
            if (acc_data.size() >= 16) break;
        end
        checks++;
        if (err_align !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_before: got %b expected 0", err_align);
        end
        @(negedge clk_100);
        #3;
        checks++;
        if (err_align !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_set: got %b expected 1", err_align);
        end
        wait_done(BL, 1'b0, 200, ok);
        @(negedge clk_100);
        push_burst(29'h720, 64'h4000, 1'b0, -1);
        wait_done(2*BL, 1'b0, 200, ok);
        checks++;
        if (!ok || err_align !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_sticky: done %0b err %b expected 1 1", ok, err_align);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (err_align !== 1'b0) begin
            failures++;
            $display("[TB] FAIL err_reset: got %b expected 0", err_align);
        end
        reset_n = 1'b1;
    endtask
`endif

    initial begin
        reset_n = 1'b0;
        wr_enable = 1'b0;
        bus.avl_ready = 1'b0;
        update_fifo();
        clear_logs();
        test_reset();
        test_single_burst();
        test_ready_toggle();
        test_back_to_back_frame();
        test_invalid_drop();
        test_reset_mid_burst();
`ifdef BURST_CHECK_EN
        test_err_align();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
